// File: rtl/atm_pkg.sv
// Shared encodings for the ATM vault controller: FSM states, error codes, note counts.
// Constants only; no logic.
// Imported by the request decoder and the controller.
package atm_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_DISPENSE = 3'd2;
  localparam logic [2:0] ST_COLLECT  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_ERROR    = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FUNDS   = 2'b01;
  localparam logic [1:0] ERR_NOTES   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Denominations expressed as a count of 50000 notes.
  localparam logic [2:0] N_50000  = 3'd1;
  localparam logic [2:0] N_100000 = 3'd2;
  localparam logic [2:0] N_200000 = 3'd4;

endpackage

// File: rtl/atm_req_decoder.sv
// Request capture: rising-edge detect on the OR of the six request lines, plus amount/direction decode.
// Latency: edge flag is combinational from the inputs against a registered previous level.
// Backpressure: none; the controller decides whether an edge is taken.
module atm_req_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       W_50000,
  input  logic       W_100000,
  input  logic       W_200000,
  input  logic       D_50000,
  input  logic       D_100000,
  input  logic       D_200000,
  output logic       req_edge,
  output logic       req_onehot,
  output logic       req_wd,
  output logic [2:0] req_n
);
  import atm_pkg::*;

  logic [5:0] req_vec;
  logic       req_any;
  logic       req_prev;

  assign req_vec = {W_50000, W_100000, W_200000, D_50000, D_100000, D_200000};
  assign req_any = |req_vec;

  // Resets high so a line already asserted when reset releases is not seen as an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) req_prev <= 1'b1;
    else        req_prev <= req_any;
  end

  assign req_edge   = req_any & ~req_prev;
  assign req_onehot = $onehot(req_vec);
  assign req_wd     = W_50000 | W_100000 | W_200000;

  always_comb begin
    req_n = '0;
    if (W_50000 | D_50000)        req_n = N_50000;
    else if (W_100000 | D_100000) req_n = N_100000;
    else if (W_200000 | D_200000) req_n = N_200000;
  end

endmodule

// File: rtl/atm_vault_controller.sv
// Vault controller: executes withdraw/deposit requests, tracks balance and note stock, reports done/error.
// Latency: request edge -> CHECK -> first note_valid on the second clock; one note per cycle when taken.
// Backpressure: note_valid holds until note_taken; TIMEOUT idle cycles abort with err_code 11.
module atm_vault_controller #(
  parameter int BAL_W        = 16,
  parameter int INIT_BALANCE = 20,
  parameter int INIT_NOTES   = 40,
  parameter int TIMEOUT      = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             W_50000,
  input  logic             W_100000,
  input  logic             W_200000,
  input  logic             D_50000,
  input  logic             D_100000,
  input  logic             D_200000,
  output logic             note_valid,
  input  logic             note_taken,
  input  logic             note_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] notes_left
);
  import atm_pkg::*;

  localparam int               TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BAL_W-1:0] BAL_MAX  = '1;
  localparam logic [BAL_W-1:0] BAL_ONE  = BAL_W'(1);

  logic [2:0]       state;
  logic [2:0]       rem;
  logic             wd_q;
  logic [TW-1:0]    tmr;
  logic             req_edge;
  logic             req_onehot;
  logic             req_wd;
  logic [2:0]       req_n;
  logic             accept;
  logic             xfer;
  logic [BAL_W-1:0] rem_ext;

  atm_req_decoder u_req_decoder (
    .clock      (clock),
    .reset      (reset),
    .W_50000    (W_50000),
    .W_100000   (W_100000),
    .W_200000   (W_200000),
    .D_50000    (D_50000),
    .D_100000   (D_100000),
    .D_200000   (D_200000),
    .req_edge   (req_edge),
    .req_onehot (req_onehot),
    .req_wd     (req_wd),
    .req_n      (req_n)
  );

  assign accept  = (state == ST_IDLE) & req_edge & req_onehot;
  assign xfer    = ((state == ST_DISPENSE) & note_taken) | ((state == ST_COLLECT) & note_in);
  assign rem_ext = BAL_W'(rem);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rem        <= '0;
      wd_q       <= 1'b0;
      tmr        <= '0;
      err_code   <= ERR_NONE;
      balance    <= BAL_W'(INIT_BALANCE);
      notes_left <= BAL_W'(INIT_NOTES);
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_CHECK;
            err_code <= ERR_NONE;
            wd_q     <= req_wd;
            rem      <= req_n;
          end
        end
        ST_CHECK: begin
          tmr <= '0;
          if (wd_q && (balance < rem_ext)) begin
            state    <= ST_ERROR;
            err_code <= ERR_FUNDS;
          end else if (wd_q && (notes_left < rem_ext)) begin
            state    <= ST_ERROR;
            err_code <= ERR_NOTES;
          end else begin
            state <= wd_q ? ST_DISPENSE : ST_COLLECT;
          end
        end
        ST_DISPENSE, ST_COLLECT: begin
          if (xfer) begin
            rem <= rem - 3'd1;
            tmr <= '0;
            if (state == ST_DISPENSE) begin
              balance    <= balance - BAL_ONE;
              notes_left <= notes_left - BAL_ONE;
            end else begin
              // Saturated notes still count against the request.
              if (balance != BAL_MAX)    balance    <= balance + BAL_ONE;
              if (notes_left != BAL_MAX) notes_left <= notes_left + BAL_ONE;
            end
            if (rem == 3'd1) state <= ST_DONE;
          end else if (tmr == TMO_LAST) begin
            state    <= ST_ERROR;
            err_code <= ERR_TIMEOUT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign note_valid = (state == ST_DISPENSE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_atm_vault_controller.sv
// Self-checking bench for atm_vault_controller: transaction table, random transactions against a
// transaction-level model, and hand-written reset / ignore / saturation sequences.
module tb_atm_vault_controller;

  localparam int TMO   = 16;
  localparam int MAX_A = 65535;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic w50 = 1'b0, w100 = 1'b0, w200 = 1'b0;
  logic d50 = 1'b0, d100 = 1'b0, d200 = 1'b0;
  logic note_taken = 1'b0, note_in = 1'b0;
  logic note_valid, busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] balance, notes_left;

  logic b_w200 = 1'b0, b_d200 = 1'b0, b_note_in = 1'b0;
  logic b_note_valid, b_busy, b_done, b_error;
  logic [1:0] b_err_code;
  logic [2:0] b_balance, b_notes_left;

  int checks = 0;
  int errors = 0;
  int m_bal, m_notes, m_err;

  always #5 clock = ~clock;

  atm_vault_controller #(.TIMEOUT(TMO)) u_dut (
    .clock(clock), .reset(reset),
    .W_50000(w50), .W_100000(w100), .W_200000(w200),
    .D_50000(d50), .D_100000(d100), .D_200000(d200),
    .note_valid(note_valid), .note_taken(note_taken), .note_in(note_in),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .balance(balance), .notes_left(notes_left)
  );

  // Tiny 3-bit vault: exercises the note-stock error and counter saturation.
  atm_vault_controller #(.BAL_W(3), .INIT_BALANCE(4), .INIT_NOTES(1), .TIMEOUT(TMO)) u_dut_b (
    .clock(clock), .reset(reset),
    .W_50000(1'b0), .W_100000(1'b0), .W_200000(b_w200),
    .D_50000(1'b0), .D_100000(1'b0), .D_200000(b_d200),
    .note_valid(b_note_valid), .note_taken(1'b0), .note_in(b_note_in),
    .busy(b_busy), .done(b_done), .error(b_error), .err_code(b_err_code),
    .balance(b_balance), .notes_left(b_notes_left)
  );

  typedef struct {
    bit wd;
    int amt;        // 0:50000 1:100000 2:200000
    int mode;       // 0 eager, 1 every third cycle, 2 never, 3 random
    int exp_err;
    int exp_bal;
    int exp_notes;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int v, input int b, input int d, input int e);
    chk({tag, ".note_valid"}, int'(note_valid), v);
    chk({tag, ".busy"},       int'(busy), b);
    chk({tag, ".done"},       int'(done), d);
    chk({tag, ".error"},      int'(error), e);
    chk({tag, ".err_code"},   int'(err_code), m_err);
    chk({tag, ".balance"},    int'(balance), m_bal);
    chk({tag, ".notes_left"}, int'(notes_left), m_notes);
  endtask

  task automatic set_req(input bit wd, input int amt, input logic v);
    if (wd) begin
      if (amt == 0) w50 = v; else if (amt == 1) w100 = v; else w200 = v;
    end else begin
      if (amt == 0) d50 = v; else if (amt == 1) d100 = v; else d200 = v;
    end
  endtask

  task automatic model_reset();
    m_bal = 20; m_notes = 40; m_err = 0;
  endtask

  // One complete request; expected behaviour comes from the balance/stock rules and an idle-cycle count.
  task automatic txn(input bit wd, input int amt, input int mode);
    int n, rem, idle, code;
    bit pulse;
    n = 1 << amt;
    set_req(wd, amt, 1'b1);
    tick();
    m_err = 0;
    check_outs("accept", 0, 1, 0, 0);
    set_req(wd, amt, 1'b0);
    tick();
    code = 0;
    if (wd && m_bal < n)        code = 1;
    else if (wd && m_notes < n) code = 2;
    if (code != 0) begin
      m_err = code;
      check_outs("check_err", 0, 1, 0, 1);
    end else begin
      rem = n; idle = 0;
      for (int c = 0; c < 200 && rem > 0 && idle < TMO; c++) begin
        check_outs("xfer", int'(wd), 1, 0, 0);
        case (mode)
          0:       pulse = 1'b1;
          1:       pulse = (c % 3 == 2);
          2:       pulse = 1'b0;
          default: pulse = ($urandom_range(0, 3) != 0);
        endcase
        if (wd) note_taken = pulse; else note_in = pulse;
        tick();
        if (pulse) begin
          rem--; idle = 0;
          if (wd) begin m_bal--; m_notes--; end
          else begin
            if (m_bal < MAX_A) m_bal++;
            if (m_notes < MAX_A) m_notes++;
          end
        end else begin
          idle++;
        end
      end
      note_taken = 1'b0; note_in = 1'b0;
      if (rem == 0) check_outs("done", 0, 1, 1, 0);
      else begin
        m_err = 3;
        check_outs("timeout", 0, 1, 0, 1);
      end
    end
    tick();
    check_outs("idle", 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    w50 = 0; w100 = 0; w200 = 0; d50 = 0; d100 = 0; d200 = 0;
    note_taken = 0; note_in = 0;
    model_reset();
    tick(); tick();
    check_outs("reset", 0, 0, 0, 0);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, vcnt;

    tbl[0]  = '{1'b1, 1, 0, 0, 18, 38};
    tbl[1]  = '{1'b0, 2, 1, 0, 22, 42};
    tbl[2]  = '{1'b1, 2, 0, 0, 18, 38};
    tbl[3]  = '{1'b1, 2, 3, 0, 14, 34};
    tbl[4]  = '{1'b1, 2, 0, 0, 10, 30};
    tbl[5]  = '{1'b1, 2, 1, 0,  6, 26};
    tbl[6]  = '{1'b1, 2, 0, 0,  2, 22};
    tbl[7]  = '{1'b1, 2, 0, 1,  2, 22};
    tbl[8]  = '{1'b1, 1, 3, 0,  0, 20};
    tbl[9]  = '{1'b1, 0, 0, 1,  0, 20};
    tbl[10] = '{1'b0, 1, 3, 0,  2, 22};
    tbl[11] = '{1'b1, 0, 2, 3,  2, 22};

    do_reset();

    // Small vault: note-stock error, then saturating deposit.
    chk("b_reset.balance", int'(b_balance), 4);
    chk("b_reset.notes", int'(b_notes_left), 1);
    b_w200 = 1'b1; tick();
    chk("b_w.busy", int'(b_busy), 1);
    b_w200 = 1'b0; tick();
    chk("b_w.error", int'(b_error), 1);
    chk("b_w.err_code", int'(b_err_code), 2);
    chk("b_w.note_valid", int'(b_note_valid), 0);
    tick();
    chk("b_w.busy_after", int'(b_busy), 0);
    chk("b_w.error_after", int'(b_error), 0);
    chk("b_w.err_hold", int'(b_err_code), 2);
    chk("b_w.balance", int'(b_balance), 4);
    chk("b_w.notes", int'(b_notes_left), 1);
    b_d200 = 1'b1; tick();
    chk("b_d.err_clear", int'(b_err_code), 0);
    b_d200 = 1'b0; tick();
    chk("b_d.busy", int'(b_busy), 1);
    b_note_in = 1'b1;
    repeat (4) tick();
    b_note_in = 1'b0;
    chk("b_d.done", int'(b_done), 1);
    chk("b_d.balance_sat", int'(b_balance), 7);
    chk("b_d.notes", int'(b_notes_left), 5);
    tick();
    chk("b_d.done_after", int'(b_done), 0);
    chk("b_d.busy_after", int'(b_busy), 0);

    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].wd, tbl[i].amt, tbl[i].mode);
      chk($sformatf("tbl%0d.err_code", i), int'(err_code), tbl[i].exp_err);
      chk($sformatf("tbl%0d.balance", i), int'(balance), tbl[i].exp_bal);
      chk($sformatf("tbl%0d.notes", i), int'(notes_left), tbl[i].exp_notes);
    end

    // Deposit, then a stray note after completion is ignored.
    txn(1'b0, 2, 1);
    note_in = 1'b1; tick();
    note_in = 1'b0; tick();
    check_outs("stray_note_in", 0, 0, 0, 0);

    // Two lines rising together are ignored.
    w50 = 1'b1; d50 = 1'b1;
    tick(); check_outs("multi1", 0, 0, 0, 0);
    tick(); check_outs("multi2", 0, 0, 0, 0);
    w50 = 1'b0; d50 = 1'b0;
    tick(); check_outs("multi3", 0, 0, 0, 0);

    // A held request level is served once.
    w50 = 1'b1; note_taken = 1'b1; dones = 0; vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      dones += int'(done);
      vcnt  += int'(note_valid);
    end
    chk("held.dones", dones, 1);
    chk("held.notes_dispensed", vcnt, 1);
    m_bal--; m_notes--; m_err = 0;
    w50 = 1'b0; note_taken = 1'b0;
    tick(); check_outs("held.idle", 0, 0, 0, 0);

    // Reset in the middle of a two-note withdrawal.
    do_reset();
    w100 = 1'b1; tick();
    tick();
    chk("mid.note_valid", int'(note_valid), 1);
    note_taken = 1'b1; tick();
    note_taken = 1'b0;
    chk("mid.balance_partial", int'(balance), 19);
    chk("mid.still_valid", int'(note_valid), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outs("mid.async", 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outs("mid.held_at_release", 0, 0, 0, 0);
    end
    w100 = 1'b0; tick();
    txn(1'b1, 0, 0);

    // Random transactions against the model.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      bit rwd;
      int ramt, rmode;
      rwd   = 1'($urandom_range(0, 1));
      ramt  = int'($urandom_range(0, 2));
      rmode = ($urandom_range(0, 9) == 0) ? 2 : ((ramt == 0) ? 0 : 3);
      if ($urandom_range(0, 3) == 0) rmode = 1;
      txn(rwd, ramt, rmode);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_vault_controller.md
Name: atm_vault_controller

Overview:
Bank-side responder for the ATM session FSM's transaction strobes (W_50000/W_100000/W_200000, D_50000/D_100000/D_200000). It executes each request:
- Withdrawals: checks balance and note stock, then hands 50000 notes to the dispenser mechanism one at a time with a valid/taken handshake.
- Deposits: counts 50000 notes from the intake sensor.
It maintains the account balance and vault note count, and reports done/error back to the session layer.

Parameters:
BAL_W, 16, width of balance and note counters (units of one 50000 note)
INIT_BALANCE, 20, balance loaded on reset (notes)
INIT_NOTES, 40, vault note stock loaded on reset
TIMEOUT, 255, max idle cycles waiting for note_taken/note_in before abort (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
W_50000 / W_100000 / W_200000  in  1 each  withdraw request levels
D_50000 / D_100000 / D_200000  in  1 each  deposit request levels
note_valid  out  1  a note is presented to the dispenser
note_taken  in  1  dispenser accepted the presented note
note_in  in  1  one deposited note detected this cycle
busy  out  1  transaction in progress (state != IDLE)
done  out  1  one-cycle pulse: transaction completed
error  out  1  one-cycle pulse: transaction aborted
err_code  out  2  00 none, 01 insufficient balance, 10 insufficient notes, 11 timeout
balance  out  BAL_W  current balance in notes
notes_left  out  BAL_W  current vault stock in notes

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; balance=INIT_BALANCE; notes_left=INIT_NOTES.
  - note_valid, busy, done, error = 0; err_code=00.
  - req_prev=1, so any request level already high at reset release is not accepted.
  - Reset mid-transaction aborts immediately. note_valid drops asynchronously. Counters return to their INIT values.
- Request capture:
  - req_any = OR of the six request inputs. A request is accepted only in IDLE, on a rising edge of req_any (req_prev=0, req_any=1).
  - A held level counts once.
  - If more than one line is high in the capture cycle, the request is ignored: no done, no error, stays IDLE.
  - Edges while busy are dropped.
- Amount decode: 50000 -> n=1; 100000 -> n=2; 200000 -> n=4.
- On accept: err_code cleared to 00, go to CHECK.
- States: IDLE, CHECK, DISPENSE, COLLECT, DONE, ERROR.
- CHECK (exactly 1 cycle):
  - Withdraw with balance<n -> ERROR, code 01.
  - Else withdraw with notes_left<n -> ERROR, code 10 (balance check has priority).
  - Else withdraw -> DISPENSE, remaining=n.
  - Deposit -> COLLECT, remaining=n.
- DISPENSE:
  - note_valid=1.
  - Each rising edge with note_valid & note_taken: remaining-1, balance-1, notes_left-1.
  - note_taken held high yields one note per cycle, with no bubble between notes.
  - After the last handshake -> DONE; note_valid is 0 in the next cycle.
- COLLECT:
  - Each cycle with note_in=1: remaining-1, balance+1, notes_left+1.
  - Both counters saturate at all-ones; a saturated note is still counted against remaining.
  - remaining reaching 0 -> DONE.
  - note_in outside COLLECT is ignored.
- Timeout:
  - A cycle counter clears on entry to DISPENSE/COLLECT and on every handshake/note_in.
  - When it reaches TIMEOUT with remaining>0 -> ERROR, code 11.
  - Notes already moved stay debited/credited; no rollback.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error=1 for one cycle, then IDLE. err_code holds its value until the next accepted request.
- busy=1 in every state except IDLE.
- Minimum latency: accept edge -> CHECK -> first note_valid is 2 cycles after the request edge.

Decomposition:
- Shared package atm_pkg:
  - state encoding localparams (IDLE..ERROR);
  - err_code constants ERR_NONE/ERR_FUNDS/ERR_NOTES/ERR_TIMEOUT;
  - denomination-to-note-count constants (1/2/4).
- One natural sub-module, atm_req_decoder: req_prev register, rising-edge detect, one-hot check, direction bit, n decode. Purely a registered edge detector plus combinational decode.
- FSM, counters and timeout stay in atm_vault_controller.

Test Plan:
- Reset, pulse W_100000, note_taken tied 1 -> note_valid high 2 consecutive cycles starting 2 cycles after the edge; balance 20->18; notes_left 40->38; done one cycle; busy falls after done.
- D_200000, note_in pulsed 4 times spaced 3 cycles -> balance 24, notes_left 44, done once; a 5th note_in after done has no effect.
- INIT_BALANCE=1, W_100000 -> error pulse, err_code=01, note_valid never asserted, balance stays 1. Separately, INIT_NOTES=1, INIT_BALANCE=20, W_200000 -> err_code=10.
- TIMEOUT=16, W_50000, note_taken held 0 -> error with err_code=11 exactly 16 cycles after DISPENSE entry; balance unchanged.
- W_50000 and D_50000 rising together -> ignored (busy stays 0). Then W_50000 alone held high 10 cycles -> exactly one note dispensed and one done.
- Reset asserted after the first of 2 notes of W_100000 -> note_valid 0 immediately, balance=20, notes_left=40; a request line still high at release is not accepted.
